riscv_trace_buffer: RTL and testbench

Parametrised execution-trace capture unit for the RISC-V core: it records one entry per retired instruction (PC, instruction, destination register, write-back value, RegWrite/MemWrite flags) into a circular buffer. A PC-match or forced trigger freezes the window after a programmable number of post-trigger entries. The captured history then drains oldest-first over a valid/ready port. It attaches beside the core top-level as the hardware replacement for per-cycle simulation monitoring, and works on silicon and FPGA.

---
 rtl/trace_pkg.sv | 33 +++
 rtl/trace_ram.sv | 25 ++
 rtl/riscv_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the execution-trace buffer: FSM encoding and the
// bit layout of one stored trace entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } trace_state_e;

    // Entry layout, LSB first: flags, rd, wdata, instr, pc.
    localparam int FLAG_REGWRITE = 0;
    localparam int FLAG_MEMWRITE = 1;
    localparam int FLAGS_LSB     = 0;
    localparam int FLAGS_W       = 2;
    localparam int RD_LSB        = 2;
    localparam int RD_W          = 5;
    localparam int WDATA_LSB     = RD_LSB + RD_W;

    function automatic int entry_w(input int xlen);
        return 3 * xlen + RD_W + FLAGS_W;
    endfunction

    function automatic int instr_lsb(input int xlen);
        return WDATA_LSB + xlen;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return WDATA_LSB + 2 * xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// The array carries no reset; only the pointers in the parent qualify its contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 103
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_trace_buffer.sv
// Execution-trace capture: records retired instructions into a circular buffer,
// freezes the window a fixed number of entries after a trigger, then drains oldest-first.
module riscv_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     force_trig,
    input  logic                     cap_valid,
    input  logic [XLEN-1:0]          cap_pc,
    input  logic [XLEN-1:0]          cap_instr,
    input  logic [XLEN-1:0]          cap_wdata,
    input  logic [4:0]               cap_rd,
    input  logic                     cap_regwrite,
    input  logic                     cap_memwrite,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [4:0]               rd_rd,
    output logic [1:0]               rd_flags,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW        = $clog2(DEPTH);
    localparam int EW        = entry_w(XLEN);
    localparam int INSTR_LSB = instr_lsb(XLEN);
    localparam int PC_LSB    = pc_lsb(XLEN);

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam logic [AW-1:0] POST_ONE  = AW'(1);

    trace_state_e    state_q;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   post_cnt;
    logic [AW:0]     count_q;
    logic            overflow_q;

    logic            capture_on;
    logic            wr_en;
    logic            pc_hit;
    logic            trig;
    logic            rd_valid_int;
    logic            pop;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;

    // arm outranks a same-cycle retire: that entry is neither stored nor able to trigger.
    assign capture_on = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign wr_en      = cap_valid && capture_on && !arm;
    assign pc_hit     = trig_en && (cap_pc == trig_pc);
    assign trig       = wr_en && (state_q == ST_ARMED) && (force_trig || pc_hit);

    // Readout handshake: an entry transfers on a cycle where rd_valid && rd_ready;
    // while rd_valid is high and rd_ready low, every rd_* output holds its value.
    assign rd_valid_int = (state_q == ST_DRAIN) && (count_q != '0);
    assign pop          = rd_valid_int && rd_ready;

    assign wr_entry = {cap_pc, cap_instr, cap_wdata, cap_rd, cap_memwrite, cap_regwrite};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (wr_entry),
        .raddr (rptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            post_cnt   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (arm) begin
            state_q    <= ST_ARMED;
            wptr       <= '0;
            rptr       <= '0;
            post_cnt   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Writes and pops live in disjoint states, so they never collide on count/rptr.
            if (wr_en) begin
                wptr <= wptr + 1'b1;
                if (count_q == FULL) begin
                    overflow_q <= 1'b1;
                    rptr       <= rptr + 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (pop) begin
                count_q <= count_q - 1'b1;
                rptr    <= rptr + 1'b1;
            end

            case (state_q)
                ST_ARMED: begin
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            post_cnt <= POST_LOAD;
                            state_q  <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == POST_ONE) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && (count_q == CNT_ONE)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are forced to zero whenever no entry is offered, so stale array data never leaks.
    assign rd_valid = rd_valid_int;
    assign rd_pc    = rd_valid_int ? rd_entry[PC_LSB +: XLEN]       : '0;
    assign rd_instr = rd_valid_int ? rd_entry[INSTR_LSB +: XLEN]    : '0;
    assign rd_wdata = rd_valid_int ? rd_entry[WDATA_LSB +: XLEN]    : '0;
    assign rd_rd    = rd_valid_int ? rd_entry[RD_LSB +: RD_W]       : '0;
    assign rd_flags = rd_valid_int ? rd_entry[FLAGS_LSB +: FLAGS_W] : '0;

    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: a per-cycle vector table for the basic
// capture window plus hand-written sequences for trigger, abort, drain and reset corners.
module tb_riscv_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic            clk = 1'b0;
    logic            reset;
    logic            arm;
    logic            trig_en;
    logic [XLEN-1:0] trig_pc;
    logic            force_trig;
    logic            cap_valid;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_instr;
    logic [XLEN-1:0] cap_wdata;
    logic [4:0]      cap_rd;
    logic            cap_regwrite;
    logic            cap_memwrite;
    logic            rd_ready;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_instr;
    logic [XLEN-1:0] rd_wdata;
    logic [4:0]      rd_rd;
    logic [1:0]      rd_flags;
    logic [1:0]      state;
    logic [4:0]      count;
    logic            overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic            arm;
        logic            cv;
        logic            ft;
        logic [XLEN-1:0] pc;
        logic [1:0]      exp_state;
        logic [4:0]      exp_count;
        logic            exp_ovf;
        logic            exp_rdv;
    } vec_t;

    vec_t vecs[20];

    riscv_trace_buffer #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .POST_TRIG (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .trig_en      (trig_en),
        .trig_pc      (trig_pc),
        .force_trig   (force_trig),
        .cap_valid    (cap_valid),
        .cap_pc       (cap_pc),
        .cap_instr    (cap_instr),
        .cap_wdata    (cap_wdata),
        .cap_rd       (cap_rd),
        .cap_regwrite (cap_regwrite),
        .cap_memwrite (cap_memwrite),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_wdata     (rd_wdata),
        .rd_rd        (rd_rd),
        .rd_flags     (rd_flags),
        .state        (state),
        .count        (count),
        .overflow     (overflow)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Per-PC payload model: every field derives from the PC, so a readout is fully checkable.
    function automatic logic [XLEN-1:0] f_instr(input logic [XLEN-1:0] pc);
        return {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [XLEN-1:0] f_wdata(input logic [XLEN-1:0] pc);
        return pc * 32'd7 + 32'd1;
    endfunction

    function automatic logic [4:0] f_rd(input logic [XLEN-1:0] pc);
        return pc[6:2];
    endfunction

    function automatic logic [1:0] f_flags(input logic [XLEN-1:0] pc);
        return pc[3:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [XLEN-1:0] pc);
        exp_q.push_back(pc);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    endtask

    // Driver: inputs change at negedge, results are sampled 1 ns after posedge.
    task automatic drive(input logic a, input logic cv, input logic ft, input logic [XLEN-1:0] pc);
        @(negedge clk);
        arm          = a;
        cap_valid    = cv;
        force_trig   = ft;
        cap_pc       = pc;
        cap_instr    = f_instr(pc);
        cap_wdata    = f_wdata(pc);
        cap_rd       = f_rd(pc);
        {cap_memwrite, cap_regwrite} = f_flags(pc);
        @(posedge clk);
        #1;
        arm        = 1'b0;
        cap_valid  = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic retire(input logic [XLEN-1:0] pc, input logic ft);
        drive(1'b0, 1'b1, ft, pc);
        push(pc);
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic [4:0] cnt,
                                input logic ovf);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    // Drain against the scoreboard; stall_first cycles with rd_ready low, then toggle or full rate.
    task automatic drain(input string tag, input int stall_first, input logic toggle);
        int cyc = 0;
        logic [XLEN-1:0] pc;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            if (cyc < stall_first) rd_ready = 1'b0;
            else if (toggle)       rd_ready = ((cyc - stall_first) % 2 == 0);
            else                   rd_ready = 1'b1;
            #1;
            pc = exp_q[0];
            check({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
            check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
            check({tag, ".rd_pc"}, rd_pc, pc);
            check({tag, ".rd_instr"}, rd_instr, f_instr(pc));
            check({tag, ".rd_wdata"}, rd_wdata, f_wdata(pc));
            check({tag, ".rd_rd"}, 32'(rd_rd), 32'(f_rd(pc)));
            check({tag, ".rd_flags"}, 32'(rd_flags), 32'(f_flags(pc)));
            if (rd_valid && rd_ready) void'(exp_q.pop_front());
            cyc++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s.timeout: %0d entries left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        check({tag, ".end_state"}, 32'(state), 32'(S_IDLE));
        check({tag, ".end_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, ".end_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        int n;

        reset = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; force_trig = 1'b0;
        cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_wdata = '0; cap_rd = '0;
        cap_regwrite = 1'b0; cap_memwrite = 1'b0; rd_ready = 1'b0;

        // Basic window table: arm, 10 plain retires, forced trigger on PC 40, 8 post entries.
        vecs[0] = '{arm: 1'b1, cv: 1'b0, ft: 1'b0, pc: '0, exp_state: S_ARMED,
                    exp_count: 5'd0, exp_ovf: 1'b0, exp_rdv: 1'b0};
        for (int i = 1; i < 20; i++) begin
            n = i;
            vecs[i].arm       = 1'b0;
            vecs[i].cv        = 1'b1;
            vecs[i].ft        = (n == 11);
            vecs[i].pc        = 32'(4 * (n - 1));
            vecs[i].exp_state = (n < 11) ? S_ARMED : (n < 19) ? S_POST : S_DRAIN;
            vecs[i].exp_count = (n > 16) ? 5'd16 : 5'(n);
            vecs[i].exp_ovf   = (n > 16);
            vecs[i].exp_rdv   = (n == 19);
        end

        // Reset values while reset is held low.
        #12;
        check_status("reset", S_IDLE, 5'd0, 1'b0);
        check("reset.rd_valid", 32'(rd_valid), 32'd0);
        check("reset.rd_pc", rd_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic window via table.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].arm, vecs[i].cv, vecs[i].ft, vecs[i].pc);
            if (vecs[i].cv) push(vecs[i].pc);
            check_status($sformatf("basic[%0d]", i), vecs[i].exp_state, vecs[i].exp_count,
                         vecs[i].exp_ovf);
            check($sformatf("basic[%0d].rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rdv));
        end
        check("basic.first_pc", exp_q[0], 32'd12);
        drain("basic", 5, 1'b1);

        // PC-match trigger at 0x20; retires after the window closes must be dropped.
        trig_en = 1'b1;
        trig_pc = 32'h20;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int pc = 0; pc <= 'h40; pc += 4) begin
            retire(32'(pc), 1'b0);
            check($sformatf("pcmatch.state@%0h", pc), 32'(state),
                  32'((pc < 'h20) ? S_ARMED : (pc < 'h40) ? S_POST : S_DRAIN));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h44);
        drive(1'b0, 1'b1, 1'b0, 32'h48);
        check_status("pcmatch.frozen", S_DRAIN, 5'd16, 1'b1);
        trig_en = 1'b0;
        drain("pcmatch", 0, 1'b0);

        // Underfill: trigger on the third retire, window holds only 11 entries.
        drive(1'b1, 1'b0, 1'b0, '0);
        retire(32'h100, 1'b0);
        retire(32'h104, 1'b0);
        retire(32'h108, 1'b1);
        check_status("under.trig", S_POST, 5'd3, 1'b0);
        for (int k = 0; k < 8; k++) retire(32'h10C + 32'(4 * k), 1'b0);
        check_status("under.done", S_DRAIN, 5'd11, 1'b0);
        drain("under", 0, 1'b0);

        // Abort during POST with a simultaneous retire, then arm alongside a forced trigger.
        drive(1'b1, 1'b0, 1'b0, '0);
        retire(32'h200, 1'b0);
        retire(32'h204, 1'b0);
        retire(32'h208, 1'b1);
        retire(32'h20C, 1'b0);
        check_status("abort.pre", S_POST, 5'd4, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h210);
        exp_q.delete();
        check_status("abort.arm_cv", S_ARMED, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h214);
        check_status("abort.arm_ft", S_ARMED, 5'd0, 1'b0);
        retire(32'h218, 1'b0);
        check_status("abort.first", S_ARMED, 5'd1, 1'b0);
        retire(32'h21C, 1'b1);
        for (int k = 0; k < 8; k++) retire(32'h220 + 32'(4 * k), 1'b0);
        check_status("abort.done", S_DRAIN, 5'd10, 1'b0);
        drain("abort", 0, 1'b0);

        // Asynchronous reset in the middle of a clock low phase during POST.
        drive(1'b1, 1'b0, 1'b0, '0);
        retire(32'h300, 1'b0);
        retire(32'h304, 1'b0);
        retire(32'h308, 1'b1);
        retire(32'h30C, 1'b0);
        check_status("areset.pre", S_POST, 5'd4, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_status("areset.now", S_IDLE, 5'd0, 1'b0);
        check("areset.rd_valid", 32'(rd_valid), 32'd0);
        check("areset.rd_pc", rd_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        drive(1'b0, 1'b1, 1'b1, 32'h310);
        check_status("areset.idle_ignores", S_IDLE, 5'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
